// File: rtl/hit_scorer.sv
// ============================================================================
// Module      : hit_scorer
// Description : Turns collision hit/miss pulses into game score, combo count,
//               multiplier and combo display enable. Inputs are synchronized
//               and edge-detected so each pulse yields exactly one event.
//               Score and combo saturate at SCORE_MAX. The score floors at 0.
// Ports       : clk              - system clock
//               reset            - asynchronous active-high reset
//               i_game_state     - 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER (sync)
//               i_correct_hit    - correct-hit level (async, multi-cycle)
//               i_incorrect_hit  - incorrect-hit level (async, multi-cycle)
//               i_beat_tick      - metronome level (miss detection only)
//               o_score          - current score, 0..SCORE_MAX
//               o_combo_count    - consecutive correct hits, 0..SCORE_MAX
//               o_combo_en       - combo display enable (registered)
//               o_mult           - current multiplier, 1..MAX_MULT
//               o_score_pulse    - one-cycle strobe on every processed event
//               o_miss_count     - beat misses, saturating at 255
// Options     : MISS_DETECT_EN   - enables beat-window miss detection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_scorer #(
  parameter int BASE_POINTS = 10,
  parameter int PENALTY     = 5,
  parameter int MULT_STEP   = 10,
  parameter int MAX_MULT    = 4,
  parameter int COMBO_SHOW  = 5,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  i_game_state,
  input  logic        i_correct_hit,
  input  logic        i_incorrect_hit,
  input  logic        i_beat_tick,
  output logic [13:0] o_score,
  output logic [13:0] o_combo_count,
  output logic        o_combo_en,
  output logic [2:0]  o_mult,
  output logic        o_score_pulse,
  output logic [7:0]  o_miss_count
);

  localparam int C_STW = $clog2(MULT_STEP + 1);

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_PLAY  = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  game_state_t w_state;
  assign w_state = game_state_t'(i_game_state);

  logic w_play;
  assign w_play = (w_state == GS_PLAY);

  // --------------------------------------------------------------------------
  // Input capture: 2-flop synchronizer plus delay flop. All flops reset to 1
  // so a level already high at reset release is not seen as a rising edge.
  // --------------------------------------------------------------------------
  logic [2:0] r_corr_sync;
  logic [2:0] r_inc_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_corr_sync <= 3'b111;
      r_inc_sync  <= 3'b111;
    end else begin
      r_corr_sync <= {r_corr_sync[1:0], i_correct_hit};
      r_inc_sync  <= {r_inc_sync[1:0], i_incorrect_hit};
    end
  end

  // Bit 1 is the synchronized level, bit 2 its one-cycle delayed copy.
  logic w_corr_ev;
  logic w_inc_ev;
  assign w_corr_ev = r_corr_sync[1] & ~r_corr_sync[2];
  assign w_inc_ev  = r_inc_sync[1]  & ~r_inc_sync[2];

  // --------------------------------------------------------------------------
  // Scoring registers
  // --------------------------------------------------------------------------
  logic [13:0]      r_score;
  logic [13:0]      r_combo;
  logic [2:0]       r_mult;
  logic [C_STW-1:0] r_step;
  logic             r_pulse;
  logic             r_combo_en;

  logic             w_miss;

`ifdef MISS_DETECT_EN
  // --------------------------------------------------------------------------
  // Beat-window miss detection
  // --------------------------------------------------------------------------
  logic [2:0] r_beat_sync;
  logic       r_armed;
  logic       r_hit_seen;
  logic [7:0] r_miss_count;
  logic       w_beat_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_sync <= 3'b111;
    end else begin
      r_beat_sync <= {r_beat_sync[1:0], i_beat_tick};
    end
  end

  assign w_beat_ev = r_beat_sync[1] & ~r_beat_sync[2];

  // A correct event landing on the closing beat still belongs to that window.
  assign w_miss = w_play & w_beat_ev & r_armed & ~(r_hit_seen | w_corr_ev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed      <= 1'b0;
      r_hit_seen   <= 1'b0;
      r_miss_count <= 8'd0;
    end else if (!w_play) begin
      // Leaving PLAY disarms, so the first beat after re-entry only arms.
      r_armed    <= 1'b0;
      r_hit_seen <= 1'b0;
      if (w_state == GS_IDLE) begin
        r_miss_count <= 8'd0;
      end
    end else begin
      if (w_beat_ev) begin
        r_armed    <= 1'b1;
        r_hit_seen <= 1'b0;
      end else if (w_corr_ev && !w_inc_ev) begin
        r_hit_seen <= 1'b1;
      end
      if (w_miss && !w_inc_ev && (r_miss_count != 8'hFF)) begin
        r_miss_count <= r_miss_count + 8'd1;
      end
    end
  end

  assign o_miss_count = r_miss_count;
`else
  logic w_unused_beat;
  assign w_unused_beat = i_beat_tick;
  assign w_miss        = 1'b0;
  assign o_miss_count  = 8'd0;
`endif

  // --------------------------------------------------------------------------
  // Next-state arithmetic. Sums and differences are one bit wider than the
  // 14-bit operands so overflow/underflow is visible before clamping.
  // --------------------------------------------------------------------------
  logic [14:0]      w_points;
  logic [14:0]      w_sum;
  logic [14:0]      w_diff;
  logic [14:0]      w_combo_sum;
  logic [13:0]      w_score_add;
  logic [13:0]      w_score_sub;
  logic [13:0]      w_combo_add;
  logic [C_STW-1:0] w_step_inc;

  assign w_points    = 15'(BASE_POINTS) * {12'd0, r_mult};
  assign w_sum       = {1'b0, r_score} + w_points;
  assign w_diff      = {1'b0, r_score} - 15'(PENALTY);
  assign w_combo_sum = {1'b0, r_combo} + 15'd1;
  assign w_score_add = (w_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_sum[13:0];
  // Borrow out of the 14-bit range shows up in bit 14.
  assign w_score_sub = w_diff[14] ? 14'd0 : w_diff[13:0];
  assign w_combo_add = (w_combo_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX)
                                                      : w_combo_sum[13:0];
  assign w_step_inc  = r_step + C_STW'(1);

  logic [13:0]      w_score_n;
  logic [13:0]      w_combo_n;
  logic [2:0]       w_mult_n;
  logic [C_STW-1:0] w_step_n;
  logic             w_pulse_n;

  // Priority inside PLAY: incorrect > miss > correct.
  always_comb begin
    w_score_n = r_score;
    w_combo_n = r_combo;
    w_mult_n  = r_mult;
    w_step_n  = r_step;
    w_pulse_n = 1'b0;
    if (w_state == GS_IDLE) begin
      w_score_n = 14'd0;
      w_combo_n = 14'd0;
      w_mult_n  = 3'd1;
      w_step_n  = '0;
    end else if (w_play) begin
      if (w_inc_ev) begin
        w_score_n = w_score_sub;
        w_combo_n = 14'd0;
        w_mult_n  = 3'd1;
        w_step_n  = '0;
        w_pulse_n = 1'b1;
      end else if (w_miss) begin
        w_combo_n = 14'd0;
        w_mult_n  = 3'd1;
        w_step_n  = '0;
        w_pulse_n = 1'b1;
      end else if (w_corr_ev) begin
        w_score_n = w_score_add;
        w_combo_n = w_combo_add;
        w_pulse_n = 1'b1;
        if (w_step_inc == C_STW'(MULT_STEP)) begin
          w_step_n = '0;
          if (r_mult < 3'(MAX_MULT)) begin
            w_mult_n = r_mult + 3'd1;
          end
        end else begin
          w_step_n = w_step_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score    <= 14'd0;
      r_combo    <= 14'd0;
      r_mult     <= 3'd1;
      r_step     <= '0;
      r_pulse    <= 1'b0;
      r_combo_en <= 1'b0;
    end else begin
      r_score    <= w_score_n;
      r_combo    <= w_combo_n;
      r_mult     <= w_mult_n;
      r_step     <= w_step_n;
      r_pulse    <= w_pulse_n;
      // Follows the registered combo, so it trails a combo change by a cycle.
      r_combo_en <= w_play && (r_combo >= 14'(COMBO_SHOW));
    end
  end

  assign o_score       = r_score;
  assign o_combo_count = r_combo;
  assign o_mult        = r_mult;
  assign o_score_pulse = r_pulse;
  assign o_combo_en    = r_combo_en;

endmodule

`default_nettype wire

// File: tb/tb_hit_scorer.sv
// ============================================================================
// Module      : tb_hit_scorer
// Description : Directed, table-driven bench for hit_scorer plus hand-written
//               sequences for penalties, saturation, reset hold and misses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_scorer;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_PLAY  = 2'd1;
  localparam logic [1:0] C_PAUSE = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  i_game_state;
  logic        i_correct_hit;
  logic        i_incorrect_hit;
  logic        i_beat_tick;
  logic [13:0] o_score;
  logic [13:0] o_combo_count;
  logic        o_combo_en;
  logic [2:0]  o_mult;
  logic        o_score_pulse;
  logic [7:0]  o_miss_count;

  int checks = 0;
  int errors = 0;
  int total_pulses = 0;

  hit_scorer dut (
    .clk             (clk),
    .reset           (reset),
    .i_game_state    (i_game_state),
    .i_correct_hit   (i_correct_hit),
    .i_incorrect_hit (i_incorrect_hit),
    .i_beat_tick     (i_beat_tick),
    .o_score         (o_score),
    .o_combo_count   (o_combo_count),
    .o_combo_en      (o_combo_en),
    .o_mult          (o_mult),
    .o_score_pulse   (o_score_pulse),
    .o_miss_count    (o_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // score_pulse is one cycle wide, so one negedge sample per strobe.
  always @(negedge clk) begin
    if (o_score_pulse) total_pulses++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] st;
    logic       c;
    logic       i;
    int         score;
    int         combo;
    int         mult;
    int         en;
    int         pulses;
  } vec_t;

  vec_t tv[23];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a pulse on the selected inputs, then let the pipeline settle.
  task automatic do_pulse(input logic c, input logic i, input logic b,
                          input int width, input int gap, output int pulses);
    int p0;
    p0 = total_pulses;
    i_correct_hit   = c;
    i_incorrect_hit = i;
    i_beat_tick     = b;
    cyc(width);
    i_correct_hit   = 1'b0;
    i_incorrect_hit = 1'b0;
    i_beat_tick     = 1'b0;
    cyc(gap);
    pulses = total_pulses - p0;
  endtask

  task automatic go_idle_then_play();
    i_game_state = C_IDLE;
    cyc(3);
    i_game_state = C_PLAY;
    cyc(2);
  endtask

  int np;

  initial begin
    // st, c, i, score, combo, mult, combo_en, pulses
    tv[0]  = '{C_PLAY,  1'b1, 1'b0,  10,  1, 1, 0, 1};
    tv[1]  = '{C_PLAY,  1'b1, 1'b0,  20,  2, 1, 0, 1};
    tv[2]  = '{C_PLAY,  1'b1, 1'b0,  30,  3, 1, 0, 1};
    tv[3]  = '{C_PLAY,  1'b1, 1'b0,  40,  4, 1, 0, 1};
    tv[4]  = '{C_PLAY,  1'b1, 1'b0,  50,  5, 1, 1, 1};
    tv[5]  = '{C_PLAY,  1'b1, 1'b0,  60,  6, 1, 1, 1};
    tv[6]  = '{C_PLAY,  1'b1, 1'b0,  70,  7, 1, 1, 1};
    tv[7]  = '{C_PLAY,  1'b1, 1'b0,  80,  8, 1, 1, 1};
    tv[8]  = '{C_PLAY,  1'b1, 1'b0,  90,  9, 1, 1, 1};
    tv[9]  = '{C_PLAY,  1'b1, 1'b0, 100, 10, 2, 1, 1};
    tv[10] = '{C_PLAY,  1'b1, 1'b0, 120, 11, 2, 1, 1};
    tv[11] = '{C_PLAY,  1'b0, 1'b1, 115,  0, 1, 0, 1};
    tv[12] = '{C_PLAY,  1'b1, 1'b0, 125,  1, 1, 0, 1};
    tv[13] = '{C_PLAY,  1'b1, 1'b0, 135,  2, 1, 0, 1};
    tv[14] = '{C_PLAY,  1'b1, 1'b0, 145,  3, 1, 0, 1};
    tv[15] = '{C_PLAY,  1'b1, 1'b0, 155,  4, 1, 0, 1};
    tv[16] = '{C_PLAY,  1'b1, 1'b0, 165,  5, 1, 1, 1};
    tv[17] = '{C_PLAY,  1'b1, 1'b1, 160,  0, 1, 0, 1};
    tv[18] = '{C_PAUSE, 1'b1, 1'b0, 160,  0, 1, 0, 0};
    tv[19] = '{C_PAUSE, 1'b1, 1'b0, 160,  0, 1, 0, 0};
    tv[20] = '{C_PLAY,  1'b1, 1'b0, 170,  1, 1, 0, 1};
    tv[21] = '{C_PAUSE, 1'b0, 1'b1, 170,  1, 1, 0, 0};
    tv[22] = '{C_PLAY,  1'b0, 1'b1, 165,  0, 1, 0, 1};

    reset           = 1'b1;
    i_game_state    = C_IDLE;
    i_correct_hit   = 1'b0;
    i_incorrect_hit = 1'b0;
    i_beat_tick     = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    chk("reset score", int'(o_score), 0);
    chk("reset combo", int'(o_combo_count), 0);
    chk("reset mult", int'(o_mult), 1);
    chk("reset combo_en", int'(o_combo_en), 0);
    chk("reset pulse", int'(o_score_pulse), 0);
    chk("reset miss", int'(o_miss_count), 0);

    i_game_state = C_PLAY;
    cyc(2);

    for (int k = 0; k < 23; k++) begin
      i_game_state = tv[k].st;
      cyc(2);
      do_pulse(tv[k].c, tv[k].i, 1'b0, 4, 8, np);
      chk($sformatf("v%0d score", k), int'(o_score), tv[k].score);
      chk($sformatf("v%0d combo", k), int'(o_combo_count), tv[k].combo);
      chk($sformatf("v%0d mult", k), int'(o_mult), tv[k].mult);
      chk($sformatf("v%0d combo_en", k), int'(o_combo_en), tv[k].en);
      chk($sformatf("v%0d pulses", k), np, tv[k].pulses);
    end

    // IDLE clears everything.
    i_game_state = C_IDLE;
    cyc(3);
    chk("idle score", int'(o_score), 0);
    chk("idle combo", int'(o_combo_count), 0);
    chk("idle mult", int'(o_mult), 1);
    chk("idle combo_en", int'(o_combo_en), 0);

    // Combo 5 / score 50, then a penalty; then floor at 0.
    i_game_state = C_PLAY;
    cyc(2);
    for (int k = 0; k < 5; k++) do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    chk("pen pre score", int'(o_score), 50);
    chk("pen pre combo_en", int'(o_combo_en), 1);
    do_pulse(1'b0, 1'b1, 1'b0, 4, 8, np);
    chk("pen score", int'(o_score), 45);
    chk("pen combo", int'(o_combo_count), 0);
    chk("pen mult", int'(o_mult), 1);
    chk("pen combo_en", int'(o_combo_en), 0);
    go_idle_then_play();
    do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    do_pulse(1'b0, 1'b1, 1'b0, 4, 8, np);
    chk("floor 5", int'(o_score), 5);
    do_pulse(1'b0, 1'b1, 1'b0, 4, 8, np);
    chk("floor 0", int'(o_score), 0);
    do_pulse(1'b0, 1'b1, 1'b0, 4, 8, np);
    chk("floor hold", int'(o_score), 0);
    chk("floor pulse", np, 1);

    // Simultaneous rise at score 50, combo 5.
    go_idle_then_play();
    for (int k = 0; k < 5; k++) do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    do_pulse(1'b1, 1'b1, 1'b0, 4, 8, np);
    chk("both score", int'(o_score), 45);
    chk("both combo", int'(o_combo_count), 0);

    // Saturation: 30 hits reach 600 at mult 4, then 235 hits of 40 overflow.
    go_idle_then_play();
    for (int k = 0; k < 265; k++) do_pulse(1'b1, 1'b0, 1'b0, 1, 3, np);
    cyc(4);
    chk("sat score", int'(o_score), 9999);
    chk("sat combo", int'(o_combo_count), 265);
    chk("sat mult", int'(o_mult), 4);
    do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    chk("sat hold score", int'(o_score), 9999);
    chk("sat hold combo", int'(o_combo_count), 266);
    chk("sat hold pulse", np, 1);

    // Beat-window miss detection.
    go_idle_then_play();
    for (int k = 0; k < 3; k++) do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    do_pulse(1'b0, 1'b0, 1'b1, 4, 8, np);
    do_pulse(1'b0, 1'b0, 1'b1, 4, 8, np);
    chk("miss score", int'(o_score), 30);
`ifdef MISS_DETECT_EN
    chk("miss combo", int'(o_combo_count), 0);
    chk("miss count", int'(o_miss_count), 1);
    chk("miss mult", int'(o_mult), 1);
`else
    chk("miss combo", int'(o_combo_count), 3);
    chk("miss count", int'(o_miss_count), 0);
`endif

    // Input held high through reset release produces no event.
    i_game_state  = C_PLAY;
    i_correct_hit = 1'b1;
    reset         = 1'b1;
    cyc(3);
    np    = total_pulses;
    reset = 1'b0;
    cyc(6);
    chk("hold score", int'(o_score), 0);
    chk("hold pulses", total_pulses - np, 0);
    i_correct_hit = 1'b0;
    cyc(3);
    do_pulse(1'b1, 1'b0, 1'b0, 4, 8, np);
    chk("post-hold score", int'(o_score), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
